// File: rtl/prefetch_pkg.sv
// prefetch_pkg: shared types and constants for the instruction prefetch controller.
// Holds the FSM state enum, the outstanding-counter width and the PC increment.
package prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } pf_state_e;

    // Largest legal MAX_OUTSTANDING; counters are sized for it.
    localparam int unsigned MAX_OUTST_LIMIT = 2;
    localparam int unsigned OUTST_W         = $clog2(MAX_OUTST_LIMIT + 1);

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pf_outst_cnt.sv
// pf_outst_cnt: outstanding-request and discard counters for prefetch_ctrl.
// Ports: inc_i (grant), dec_i (rvalid), reload_i (discard := outstanding'),
//        room_o, any_o (outstanding!=0), discard_o (discard!=0), pending_o (outstanding'!=0).
module pf_outst_cnt
    import prefetch_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    input  logic reload_i,
    output logic room_o,
    output logic any_o,
    output logic discard_o,
    output logic pending_o
);

    logic [OUTST_W-1:0] outst_q, outst_d;
    logic [OUTST_W-1:0] discard_q, discard_d;
    logic               inc_ok, dec_ok;

    assign room_o    = outst_q < OUTST_W'(MAX_OUTSTANDING);
    assign any_o     = outst_q != '0;
    assign discard_o = discard_q != '0;
    assign pending_o = outst_d != '0;

    // A response with nothing outstanding is a bus protocol error: ignored.
    assign inc_ok = inc_i & room_o;
    assign dec_ok = dec_i & any_o;

    always_comb begin
        outst_d   = outst_q;
        discard_d = discard_q;
        if (inc_ok && !dec_ok) begin
            outst_d = outst_q + OUTST_W'(1);
        end else if (dec_ok && !inc_ok) begin
            outst_d = outst_q - OUTST_W'(1);
        end
        // Reload counts a grant in this cycle and drops a response in this cycle.
        if (reload_i) begin
            discard_d = outst_d;
        end else if (dec_ok && discard_o) begin
            discard_d = discard_q - OUTST_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: rtl/prefetch_ctrl.sv
// prefetch_ctrl: owns the fetch PC, issues word requests on the IMEM req/gnt/rvalid
// bus and pushes returned words into fetch_fifo; redirects clear the FIFO, drop
// in-flight responses and restart at the new target.
// Ports: fetch_en_i, redirect_i/redirect_addr_i, fifo_ready_i, fifo_push_o/_instr_o/
//        _clear_o/_misaligned_o, imem_req_o/_addr_o/_gnt_i/_rvalid_i/_rdata_i, busy_o.
// Option PREFETCH_ERR_EN: adds imem_err_i / fetch_err_o; an error parks the
// controller in IDLE until the next redirect.
module prefetch_ctrl
    import prefetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        fifo_ready_i,
    output logic        fifo_push_o,
    output logic [31:0] fifo_instr_o,
    output logic        fifo_clear_o,
    output logic        fifo_misaligned_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
`ifdef PREFETCH_ERR_EN
    input  logic        imem_err_i,
    output logic        fetch_err_o,
`endif
    output logic        busy_o
);

    pf_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        mis_q, mis_d;
    logic        hold_q, hold_d;
    logic        lock;
    logic        room, any, discard, pending;
    logic        req, grant, good, data_ok, err_fire, push;
    logic        unused_addr0;

    assign unused_addr0 = redirect_addr_i[0];

    pf_outst_cnt #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .inc_i    (grant),
        .dec_i    (imem_rvalid_i),
        .reload_i (redirect_i | err_fire),
        .room_o   (room),
        .any_o    (any),
        .discard_o(discard),
        .pending_o(pending)
    );

    // hold_q keeps an ungranted request asserted with a stable address.
    assign req   = (state_q == REQ) &
                   (hold_q | (fetch_en_i & fifo_ready_i & room));
    assign grant = req & imem_gnt_i;
    assign good  = imem_rvalid_i & any & ~discard;

`ifdef PREFETCH_ERR_EN
    logic lock_q;
    assign err_fire    = good & imem_err_i & ~redirect_i;
    assign data_ok     = good & ~imem_err_i;
    assign fetch_err_o = err_fire;
    assign lock        = lock_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
        end else if (redirect_i) begin
            lock_q <= 1'b0;
        end else if (err_fire) begin
            lock_q <= 1'b1;
        end
    end
`else
    assign err_fire = 1'b0;
    assign data_ok  = good;
    assign lock     = 1'b0;
`endif

    assign push = data_ok & ~redirect_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mis_d   = mis_q;
        hold_d  = req & ~imem_gnt_i & ~redirect_i & ~err_fire;
        unique case (state_q)
            IDLE: begin
                if (fetch_en_i && !lock) state_d = REQ;
            end
            REQ: begin
                if (!fetch_en_i && !(req && !imem_gnt_i)) state_d = IDLE;
            end
            FLUSH: begin
                if (!discard) state_d = fetch_en_i ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (grant) pc_d = pc_q + PC_INC;
        if (push) mis_d = 1'b0;
        if (err_fire) state_d = IDLE;
        if (redirect_i) begin
            pc_d  = {redirect_addr_i[31:2], 2'b00};
            mis_d = redirect_addr_i[1];
            if (pending) state_d = FLUSH;
            else         state_d = fetch_en_i ? REQ : IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= {BOOT_ADDR[31:2], 2'b00};
            mis_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
            hold_q  <= hold_d;
        end
    end

    assign imem_req_o        = req;
    assign imem_addr_o       = pc_q;
    assign fifo_push_o       = push;
    assign fifo_instr_o      = push ? imem_rdata_i : 32'h0;
    assign fifo_clear_o      = redirect_i;
    assign fifo_misaligned_o = push & mis_q;
    assign busy_o            = any | (state_q != IDLE);

endmodule

// File: tb/tb_prefetch_ctrl.sv
// tb_prefetch_ctrl: directed and randomized checks of prefetch_ctrl against a
// request-queue/epoch reference model with an IMEM slave model.
module tb_prefetch_ctrl;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        fetch_en_i, redirect_i, fifo_ready_i;
    logic [31:0] redirect_addr_i;
    logic        fifo_push_o, fifo_clear_o, fifo_misaligned_o;
    logic [31:0] fifo_instr_o;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        busy_o;
`ifdef PREFETCH_ERR_EN
    logic        imem_err_i, fetch_err_o;
`endif

    always #5 clk = ~clk;

    prefetch_ctrl #(
        .BOOT_ADDR(32'h0000_0000),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .fetch_en_i       (fetch_en_i),
        .redirect_i       (redirect_i),
        .redirect_addr_i  (redirect_addr_i),
        .fifo_ready_i     (fifo_ready_i),
        .fifo_push_o      (fifo_push_o),
        .fifo_instr_o     (fifo_instr_o),
        .fifo_clear_o     (fifo_clear_o),
        .fifo_misaligned_o(fifo_misaligned_o),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
`ifdef PREFETCH_ERR_EN
        .imem_err_i       (imem_err_i),
        .fetch_err_o      (fetch_err_o),
`endif
        .busy_o           (busy_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          ep;
    } req_t;

    req_t        q[$];
    logic [31:0] mpc;
    int          epoch;
    bit          mis_flag, held, locked, fixed_data, drv_err;
    int          n_cmp, n_err, n_push;
    logic        o_req, o_push, o_mis, o_clear, o_busy, o_ferr;
    logic [31:0] o_addr, o_instr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return fixed_data ? 32'h0001_0013 : (a ^ 32'h5A5A_0013);
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (q[i]) if (q[i].ep != epoch) n++;
        return n;
    endfunction

    task automatic model_reset();
        q.delete();
        mpc = 32'h0;
        epoch = 0;
        mis_flag = 0;
        held = 0;
        locked = 0;
    endtask

    // One clock cycle: drive at the falling edge, check, update the model.
    task automatic step(input bit en, input bit rdy, input bit rd,
                        input logic [31:0] ra, input bit g, input bit rv);
        bit resp, fresh, exp_push, exp_err;
        fetch_en_i      = en;
        fifo_ready_i    = rdy;
        redirect_i      = rd;
        redirect_addr_i = ra;
        imem_rvalid_i   = rv;
        imem_rdata_i    = (q.size() > 0) ? q[0].data : 32'hDEAD_BEEF;
`ifdef PREFETCH_ERR_EN
        imem_err_i      = drv_err;
`endif
        #1;
        imem_gnt_i = g & imem_req_o;
        #1;
        o_req   = imem_req_o;
        o_addr  = imem_addr_o;
        o_push  = fifo_push_o;
        o_instr = fifo_instr_o;
        o_mis   = fifo_misaligned_o;
        o_clear = fifo_clear_o;
        o_busy  = busy_o;
`ifdef PREFETCH_ERR_EN
        o_ferr  = fetch_err_o;
`else
        o_ferr  = 1'b0;
`endif
        resp     = rv && q.size() > 0;
        fresh    = resp && q[0].ep == epoch;
        exp_err  = fresh && drv_err && !rd;
        exp_push = fresh && !rd && !drv_err;
        chk("clear", o_clear, rd);
        chk("push", o_push, exp_push);
        chk("misaligned", o_mis, exp_push & mis_flag);
        if (exp_push) chk("instr", o_instr, q[0].data);
        if (o_req) chk("req_addr", o_addr, mpc);
        if (held) chk("req_held", o_req, 1);
        if (o_req && !held)
            chk("req_allowed", en && rdy && q.size() < MAXO && !locked, 1);
        if (o_req && !rd) chk("req_during_flush", stale_cnt(), 0);
        if (q.size() > 0) chk("busy", o_busy, 1);
`ifdef PREFETCH_ERR_EN
        chk("fetch_err", o_ferr, exp_err);
`endif
        if (exp_push) n_push++;
        held = o_req && !imem_gnt_i && !rd && !exp_err;
        if (resp) void'(q.pop_front());
        if (o_req && imem_gnt_i) begin
            q.push_back('{mpc, word_at(mpc), epoch});
            mpc = mpc + 32'd4;
        end
        if (exp_push) mis_flag = 0;
        if (exp_err) begin
            locked = 1;
            epoch++;
        end
        if (rd) begin
            epoch++;
            mpc = {ra[31:2], 2'b00};
            mis_flag = ra[1];
            locked = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) step(1, 0, 0, 0, 1, 1);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] a);
        bit seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step(1, 1, 0, 0, 1, 0);
            seen = o_req;
        end
        chk({tag, "_req"}, seen, 1);
        chk({tag, "_addr"}, o_addr, a);
    endtask

    initial begin
        logic [31:0] pc;
        int base_push;
        n_cmp = 0;
        n_err = 0;
        n_push = 0;
        fixed_data = 0;
        drv_err = 0;
        model_reset();
        rst_ni = 1'b0;
        fetch_en_i = 0; redirect_i = 0; redirect_addr_i = 0;
        fifo_ready_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
`ifdef PREFETCH_ERR_EN
        imem_err_i = 0;
`endif
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req", imem_req_o, 0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_push", fifo_push_o, 0);
        chk("rst_clear", fifo_clear_o, 0);
        chk("rst_mis", fifo_misaligned_o, 0);
        chk("rst_busy", busy_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Back-to-back fetch, immediate grant, response one cycle later.
        fixed_data = 1;
        step(1, 1, 0, 0, 1, 0);
        chk("boot_idle_req", o_req, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 1, q.size() > 0);
            chk("seq_req", o_req, 1);
            chk("seq_addr", o_addr, 32'(i * 4));
            if (i > 0) begin
                chk("seq_push", o_push, 1);
                chk("seq_instr", o_instr, 32'h0001_0013);
            end
        end
        drain();
        fixed_data = 0;

        // FIFO full stalls requests without moving the address.
        pc = mpc;
        repeat (3) begin
            step(1, 0, 0, 0, 1, 0);
            chk("full_req", o_req, 0);
            chk("full_addr", o_addr, pc);
        end
        step(1, 1, 0, 0, 1, 0);
        chk("resume_req", o_req, 1);
        chk("resume_addr", o_addr, pc);

        // Delayed grant: request and address held.
        pc = mpc;
        repeat (3) begin
            step(1, 1, 0, 0, 0, q.size() > 0);
            chk("wait_req", o_req, 1);
            chk("wait_addr", o_addr, pc);
        end
        step(1, 1, 0, 0, 1, 0);
        chk("gnt_addr", o_addr, pc);
        step(1, 1, 0, 0, 0, 0);
        chk("after_gnt_addr", o_addr, pc + 32'd4);

        // Redirect to 0x102 with one request outstanding.
        drain();
        step(1, 1, 0, 0, 1, 0);
        step(1, 1, 1, 32'h0000_0102, 0, 0);
        chk("redir_clear", o_clear, 1);
        step(1, 1, 0, 0, 1, 1);
        chk("stale_push", o_push, 0);
        chk("flush_req", o_req, 0);
        wait_req("redir", 32'h0000_0100);
        step(1, 1, 0, 0, 0, 1);
        chk("first_push", o_push, 1);
        chk("first_mis", o_mis, 1);
        step(1, 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 1);
        chk("second_push", o_push, 1);
        chk("second_mis", o_mis, 0);

        // Redirect coinciding with grant and response.
        step(1, 1, 0, 0, 1, 0);
        step(1, 1, 1, 32'h0000_0200, 1, 1);
        chk("rgr_req", o_req, 1);
        chk("rgr_push", o_push, 0);
        chk("rgr_clear", o_clear, 1);
        step(1, 1, 0, 0, 1, 1);
        chk("rgr_discard", o_push, 0);
        wait_req("rgr", 32'h0000_0200);
        step(1, 1, 0, 0, 0, 1);
        chk("rgr_next_push", o_push, 1);
        chk("rgr_next_instr", o_instr, 32'h0000_0200 ^ 32'h5A5A_0013);

        // Response with nothing outstanding is ignored.
        drain();
        step(1, 0, 0, 0, 0, 1);
        chk("spurious_push", o_push, 0);

`ifdef PREFETCH_ERR_EN
        step(1, 1, 0, 0, 1, 0);
        drv_err = 1;
        step(1, 1, 0, 0, 0, 1);
        drv_err = 0;
        chk("err_pulse", o_ferr, 1);
        chk("err_push", o_push, 0);
        repeat (3) begin
            step(1, 1, 0, 0, 1, q.size() > 0);
            chk("err_locked_req", o_req, 0);
            chk("err_pulse_end", o_ferr, 0);
        end
        step(1, 1, 1, 32'h0000_0300, 0, 0);
        wait_req("err_redir", 32'h0000_0300);
`endif

        // Randomized traffic against the model.
        base_push = n_push;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 19) == 0, $urandom,
                 $urandom_range(0, 9) < 6,
                 ($urandom_range(0, 1) == 1) && q.size() > 0);
        end
        chk("rand_progress", n_push > base_push, 1);

        // Stop fetching and let everything retire.
        for (int i = 0; i < 30; i++) begin
            step(0, 1, 0, 0, 1, q.size() > 0);
            if (!o_busy && q.size() == 0) break;
        end
        chk("final_busy", o_busy, 0);

        // Asynchronous reset in the middle of traffic.
        step(1, 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1, 0);
        imem_gnt_i = 0;
        imem_rvalid_i = 0;
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_req", imem_req_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_addr", imem_addr_o, 32'h0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        step(1, 1, 0, 0, 1, 0);
        wait_req("arst_restart", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prefetch_ctrl.md
Name: prefetch_ctrl

Overview:
Upstream fetch stage that feeds fetch_fifo. Owns the fetch PC and issues word-aligned requests on the IMEM request/grant/rvalid bus. Pushes returned 32-bit words into the FIFO and, on a redirect (branch/jump/trap), clears the FIFO, discards in-flight responses and restarts at the new target.

Parameters:
BOOT_ADDR, 32'h0000_0000, fetch PC after reset
MAX_OUTSTANDING, 1, maximum granted-but-unreturned IMEM requests; legal 1..2

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
fetch_en_i  input  1  core enables fetching
redirect_i  input  1  one-cycle pulse: restart fetch at redirect_addr_i
redirect_addr_i  input  32  new PC; bit 0 ignored; bit 1 may be set
fifo_ready_i  input  1  FIFO fetch_req_o; at least one entry free
fifo_push_o  output  1  push_req_i to FIFO
fifo_instr_o  output  32  in_instr_i to FIFO
fifo_clear_o  output  1  clear_i to FIFO
fifo_misaligned_o  output  1  pushed word's lower halfword is not an instruction (first word after redirect with addr[1]=1)
imem_req_o  output  1  request valid
imem_addr_o  output  32  word address, bits[1:0]=0
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response data valid
imem_rdata_i  input  32  response data
busy_o  output  1  outstanding_q != 0 or state != IDLE

Behaviour:
- Reset: state=IDLE; pc_q=BOOT_ADDR & ~3; outstanding_q=0; discard_q=0; misalign_q=0; all outputs 0.
- States:
  - IDLE: fetch_en_i=1 -> REQ.
  - REQ: imem_req_o=1 while fifo_ready_i & (outstanding_q < MAX_OUTSTANDING), else 0. Request accepted (req & gnt): pc_q += 4, outstanding_q++. fetch_en_i=0 -> IDLE after the current handshake completes; imem_req_o must not drop while ungranted within a cycle.
  - FLUSH: entered on redirect while outstanding_q != 0 (after the update below). imem_req_o=0 until discard_q==0, then -> REQ.
- imem_addr_o = pc_q; stable while imem_req_o=1 and gnt=0.
- Response: imem_rvalid_i & discard_q==0 -> fifo_push_o=1 and fifo_instr_o=imem_rdata_i in the same cycle (combinational, zero latency); outstanding_q--. imem_rvalid_i & discard_q!=0 -> no push; discard_q--, outstanding_q--.
- fifo_misaligned_o = fifo_push_o & misalign_q; misalign_q clears on that push.
- Redirect (highest priority):
  - fifo_clear_o=1 the same cycle.
  - Any push that cycle is suppressed.
  - pc_q <= {redirect_addr_i[31:2],2'b00}.
  - misalign_q <= redirect_addr_i[1].
  - discard_q <= outstanding_q' (count including a grant in that cycle, minus a response in that cycle).
  - Next state = FLUSH if discard_q' != 0, else REQ (IDLE if fetch_en_i=0).
  - A request granted in the redirect cycle targets the old PC and is counted for discard.
- Simultaneous gnt and rvalid: outstanding_q unchanged.
- Redirect during FLUSH: discard_q reloaded per the same rule; pc_q overwritten.
- Counter saturation: outstanding_q never exceeds MAX_OUTSTANDING. rvalid with outstanding_q==0 is a protocol error: ignored, counters unchanged.
- Asynchronous reset mid-transaction: all state cleared; the bus slave must also be reset.

Optional Feature:
PREFETCH_ERR_EN
- Defined: adds imem_err_i (input, 1, qualifies rvalid) and fetch_err_o (output, 1).
  - Response with err and no discard -> no push; fetch_err_o pulses 1 cycle.
  - Controller -> IDLE, req deasserted until the next redirect.
- Undefined: ports absent; every response is treated as good.

Decomposition:
- Package prefetch_pkg:
  - pf_state_e enum (IDLE, REQ, FLUSH).
  - OUTST_W = $clog2(MAX_OUTSTANDING+1).
  - PC_INC = 32'd4.
- Sub-module pf_outst_cnt holds outstanding_q/discard_q and their increment/decrement/reload logic. Top holds the FSM, PC and FIFO interface.

Test Plan:
- Reset release, fetch_en_i=1, slave gnt immediate, rvalid next cycle with data 32'h0001_0013:
  - imem_addr_o 0x0, 0x4, 0x8…
  - fifo_push_o with data 32'h0001_0013 the same cycle as rvalid.
- fifo_ready_i=0 -> imem_req_o=0 and no addr change. fifo_ready_i=1 -> request resumes at the same pc.
- gnt delayed 3 cycles -> imem_req_o and imem_addr_o held stable; pc_q advances only on the gnt cycle.
- Redirect to 0x0000_0102 with 1 outstanding:
  - fifo_clear_o=1 that cycle.
  - Stale response dropped (no push).
  - Next request addr 0x100.
  - First push has fifo_misaligned_o=1, the following push 0.
- Redirect in the same cycle as rvalid and gnt:
  - Push suppressed, discard_q=1.
  - The next rvalid is discarded; the following response is pushed.
- With PREFETCH_ERR_EN: err response -> fetch_err_o 1-cycle pulse, no push, imem_req_o stays 0 until the next redirect.
